// File: rtl/rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_pkg
//  Description : Shared constants and types for the 8-way round-robin
//                arbiter: requester count, index width, FSM state encoding
//                and the pointer value loaded at reset.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // Pointer holds the last granted index; 7 makes the first search start at 0.
    localparam logic [IDX_W-1:0] RST_PTR = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage : rr_arbiter_pkg
`default_nettype wire

// File: rtl/rr_arbiter_prio_enc8.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc8
//  Description : 8-input priority encoder, lowest set bit wins.
//  Ports       : i_vec [7:0] - input vector
//                o_idx [2:0] - index of the lowest set bit (0 when none set)
//                o_vld       - high when any bit of i_vec is set
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc8
    import rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    always_comb begin
        o_idx = '0;
        // Scan from the top so the lowest set bit is the last assignment.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_vld = |i_vec;

endmodule : prio_enc8
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : 8-way round-robin arbiter with release-based ownership and
//                hold-time preemption. The owner keeps the grant while its
//                request stays high; after MAX_HOLD cycles it is preempted
//                if any other requester is waiting.
//  Ports       : clk         - clock, rising edge
//                rst         - synchronous active-high reset
//                req [7:0]   - request vector
//                gnt [7:0]   - registered one-hot grant
//                gnt_idx[2:0]- registered index of the owner (0 when idle)
//                gnt_vld     - registered, high when gnt is non-zero
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16     // legal range 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [7:0]         r_hold_cnt;
    logic [N_REQ-1:0]   r_gnt;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic               r_gnt_vld;

    logic [IDX_W-1:0]   w_start;
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]   w_enc_idx;
    logic               w_enc_vld;
    logic [IDX_W-1:0]   w_winner;
    logic [N_REQ-1:0]   w_others;
    logic               w_release;
    logic               w_preempt;

    // Rotate right so that bit 0 of w_rot is req[ptr+1]; the lowest set bit
    // of the rotated vector is then the first requester after the owner.
    assign w_start  = r_ptr + 3'd1;
    assign w_dbl    = {req, req};
    assign w_rot    = w_dbl[w_start +: N_REQ];
    assign w_winner = w_start + w_enc_idx;

    prio_enc8 u_prio_enc8 (
        .i_vec (w_rot),
        .o_idx (w_enc_idx),
        .o_vld (w_enc_vld)
    );

    assign w_others  = req & ~(8'b1 << r_ptr);
    assign w_release = ~req[r_ptr];
    assign w_preempt = (r_hold_cnt == c_HOLD_LAST) && (|w_others);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= RST_PTR;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_gnt_vld  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_enc_vld) begin
                        r_state    <= ST_GRANT;
                        r_ptr      <= w_winner;
                        r_hold_cnt <= '0;
                        r_gnt      <= 8'b1 << w_winner;
                        r_gnt_idx  <= w_winner;
                        r_gnt_vld  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // Release and preemption share one path: both re-arbitrate.
                    // The search starts after the owner, so on preemption the
                    // owner can only win if nobody else asks, which cannot
                    // happen since preemption needs another requester.
                    if (w_release || w_preempt) begin
                        if (w_enc_vld) begin
                            r_ptr      <= w_winner;
                            r_hold_cnt <= '0;
                            r_gnt      <= 8'b1 << w_winner;
                            r_gnt_idx  <= w_winner;
                            r_gnt_vld  <= 1'b1;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_gnt      <= '0;
                            r_gnt_idx  <= '0;
                            r_gnt_vld  <= 1'b0;
                        end
                    end else if (r_hold_cnt != c_HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;

endmodule : rr_arbiter
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter
//  Description : Directed, table-driven bench for rr_arbiter (MAX_HOLD=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       rst;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic [7:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [7:0] q, input logic [7:0] g, input logic [2:0] i);
        vec_t v;
        v.rst = r;
        v.req = q;
        v.gnt = g;
        v.idx = i;
        v.vld = (g != 8'h00);
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;

        // Reset held with no requests, then with requests that must be ignored.
        for (int k = 0; k < 5; k++) add(1'b1, 8'h00, 8'h00, 3'd0);
        add(1'b1, 8'hFF, 8'h00, 3'd0);
        // First grant goes to 0, release hands over to 7 back-to-back.
        add(1'b0, 8'h81, 8'h01, 3'd0);
        add(1'b0, 8'h80, 8'h80, 3'd7);
        add(1'b0, 8'h80, 8'h80, 3'd7);
        add(1'b0, 8'h00, 8'h00, 3'd0);
        // Full rotation, each owner releasing after one cycle.
        add(1'b0, 8'hFF, 8'h01, 3'd0);
        add(1'b0, 8'hFE, 8'h02, 3'd1);
        add(1'b0, 8'hFD, 8'h04, 3'd2);
        add(1'b0, 8'hFB, 8'h08, 3'd3);
        add(1'b0, 8'hF7, 8'h10, 3'd4);
        add(1'b0, 8'hEF, 8'h20, 3'd5);
        add(1'b0, 8'hDF, 8'h40, 3'd6);
        add(1'b0, 8'hBF, 8'h80, 3'd7);
        add(1'b0, 8'h7F, 8'h01, 3'd0);
        add(1'b0, 8'h00, 8'h00, 3'd0);
        // Hold-time preemption with two constant requesters.
        add(1'b1, 8'h00, 8'h00, 3'd0);
        for (int k = 0; k < 4; k++) add(1'b0, 8'h03, 8'h01, 3'd0);
        for (int k = 0; k < 4; k++) add(1'b0, 8'h03, 8'h02, 3'd1);
        add(1'b0, 8'h03, 8'h01, 3'd0);
        // Non-owner churn before the hold limit does not disturb the owner.
        add(1'b0, 8'h01, 8'h01, 3'd0);
        add(1'b0, 8'h41, 8'h01, 3'd0);
        add(1'b0, 8'h00, 8'h00, 3'd0);
        // Reset mid-grant drops the grant and restarts the search at 0.
        add(1'b1, 8'h00, 8'h00, 3'd0);
        add(1'b0, 8'h08, 8'h08, 3'd3);
        add(1'b1, 8'h09, 8'h00, 3'd0);
        add(1'b0, 8'h09, 8'h01, 3'd0);
        add(1'b0, 8'h00, 8'h00, 3'd0);

        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].req);
            chk($sformatf("vec%0d_gnt", n), gnt, vecs[n].gnt);
            chk($sformatf("vec%0d_idx", n), {5'd0, gnt_idx}, {5'd0, vecs[n].idx});
            chk($sformatf("vec%0d_vld", n), {7'd0, gnt_vld}, {7'd0, vecs[n].vld});
        end

        // Lone requester keeps the grant indefinitely; hold counter saturates.
        step(1'b1, 8'h00);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 8'h04);
            chk($sformatf("solo%0d_gnt", k), gnt, 8'h04);
            chk($sformatf("solo%0d_hold", k), dut.r_hold_cnt, (k < 3) ? 8'(k) : 8'd3);
        end
        // A new requester arriving after saturation preempts at the next edge,
        // with the search wrapping from 3 past 7 to 0.
        step(1'b0, 8'h05);
        chk("preempt_wrap_gnt", gnt, 8'h01);
        chk("preempt_wrap_idx", {5'd0, gnt_idx}, 8'd0);
        chk("preempt_wrap_hold", dut.r_hold_cnt, 8'd0);
        // Simultaneous release and preemption: owner 0 drops, 2 takes over.
        step(1'b0, 8'h05);
        step(1'b0, 8'h05);
        step(1'b0, 8'h05);
        step(1'b0, 8'h04);
        chk("rel_pre_gnt", gnt, 8'h04);
        chk("rel_pre_idx", {5'd0, gnt_idx}, 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rr_arbiter
`default_nettype wire

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive grant cycles per owner while other requests are pending; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  8  request vector, one bit per requester; the owner holds its bit high while using the shared resource.
REQ-005 Port: gnt  output  8  registered one-hot grant vector; all zero when idle.
REQ-006 Port: gnt_idx  output  3  registered binary index of the grant owner; 0 when idle.
REQ-007 Port: gnt_vld  output  1  registered; high when and only when gnt is non-zero.

Function
REQ-008 The arbiter SHALL be a two-state machine: IDLE (no owner) and GRANT (one owner).
REQ-009 The arbiter SHALL keep a 3-bit pointer ptr holding the last granted index.
REQ-010 Arbitration SHALL search req starting at index (ptr+1) mod 8, ascending with wrap, and select the first set bit.
REQ-011 In IDLE, when req is non-zero at an edge, the arbiter SHALL enter GRANT with the selected winner; gnt, gnt_idx and gnt_vld SHALL reflect the winner from the next cycle (latency 1 cycle).
REQ-012 In IDLE with req zero, the arbiter SHALL stay in IDLE with all outputs zero.
REQ-013 On every new grant, ptr SHALL load the winner index and hold_cnt (8-bit) SHALL clear to 0.
REQ-014 In GRANT, hold_cnt SHALL increment each cycle and saturate at MAX_HOLD-1.
REQ-015 Release: if req[owner] is low at an edge in GRANT, re-arbitration SHALL occur at that edge.
REQ-016 Preemption: if hold_cnt equals MAX_HOLD-1 and (req with the owner bit cleared) is non-zero at an edge, re-arbitration SHALL occur at that edge.
REQ-017 On re-arbitration, a winner SHALL be granted back-to-back, with no idle cycle, with state remaining GRANT; if no request is eligible, state SHALL go to IDLE and outputs SHALL clear the next cycle.
REQ-018 Because the search starts after the owner, the previous owner SHALL have lowest priority at re-arbitration; no explicit masking is required.
REQ-019 With no other requests pending, the owner SHALL retain the grant indefinitely regardless of hold_cnt.
REQ-020 Simultaneous release and preemption conditions SHALL be handled as a release.
REQ-021 gnt SHALL never have more than one bit set, and gnt_idx SHALL always equal the index of the set bit.
REQ-022 Requests arriving or dropping for non-owners SHALL have no effect on the current grant except through REQ-016.

Reset
REQ-023 On a rst edge, the state SHALL become IDLE, ptr SHALL become 7 (first search starts at 0), hold_cnt SHALL become 0, and gnt, gnt_idx and gnt_vld SHALL become 0, irrespective of req.
REQ-024 Reset asserted mid-grant SHALL drop the grant on the following cycle, with no completion of the hold interval.
REQ-025 req SHALL be ignored while rst is high.

Structure
REQ-026 A shared package SHALL hold N_REQ=8, IDX_W=3, the state encoding (IDLE, GRANT) and the reset pointer value 7.
REQ-027 One sub-module prio_enc8 SHALL be used: 8-bit input, 3-bit index of the lowest set bit, plus a valid flag; it is instantiated once on the rotated request vector, and its result is added to the rotation offset mod 8.
REQ-028 All outputs SHALL come directly from registers.

Verification
REQ-029 Reset with req=0x00 held for 5 cycles -> gnt=0x00, gnt_idx=0, gnt_vld=0 throughout.
REQ-030 After reset, req=0x81 -> next cycle gnt=0x01 and gnt_idx=0; drop req[0] -> next cycle gnt=0x80 and gnt_idx=7, with no idle cycle.
REQ-031 req=0xFF, each owner releasing after 1 cycle -> grant order 0,1,2,3,4,5,6,7,0.
REQ-032 MAX_HOLD=4, req=0x03 constant -> gnt=0x01 for 4 cycles, then 0x02 for 4 cycles, then 0x01.
REQ-033 MAX_HOLD=4, req=0x04 only, held 10 cycles -> gnt=0x04 for all 10 cycles, and hold_cnt saturates at 3.
REQ-034 rst pulsed while gnt=0x08, then req=0x09 -> gnt=0x00 for the cycle after rst, then gnt=0x01 (ptr reset to 7).
